flash_pin_arbiter: RTL and testbench
====================================

# flash_pin_arbiter

Arbitrates the single shared Q-SPI flash pin set between two masters: the legacy SPI bridge and the memory-mapped QSPI controller. It replaces ad-hoc combinational pin merging with an explicit grant FSM, so only one master ever drives the pins. It inserts a guaranteed chip-select-high turnaround between owners and flags masters that hold the bus too long. It sits at top level between the system core's flash ports and the flash pad tri-state buffers.

## Interface
- pTURNAROUND, 2: idle cycles (CSn high, SCK low) between owners; legal range 1..15.
- pMAX_HOLD, 65535: cycles an owner may hold the grant while the other master waits before the timeout flag sets; 16-bit.
- iCLK  in  1  system clock; all logic on its rising edge.
- iRESET  in  1  reset, synchronous, active-high.
- iSPI_REQ  in  1  SPI bridge bus request.
- oSPI_GNT  out  1  SPI bridge grant.
- iSPI_SCK, iSPI_MOSI, iSPI_CSn  in  1 each  SPI bridge pin drive.
- oSPI_MISO  out  1  flash IO1 to the SPI bridge.
- iQSPI_REQ  in  1  QSPI controller bus request.
- oQSPI_GNT  out  1  QSPI controller grant.
- iQSPI_SCK, iQSPI_NCS  in  1 each  QSPI clock and chip select.
- iQSPI_DOUT  in  4  QSPI IO data out.
- iQSPI_DOE  in  4  QSPI IO output enables.
- oQSPI_DIN  out  4  flash IO to the QSPI controller.
- oFLASH_SCK, oFLASH_CSn  out  1 each  flash clock and chip select pins.
- oFLASH_DOUT  out  4  IO[3:0] drive values; IO3=HOLD, IO2=WP.
- oFLASH_DOE  out  4  IO[3:0] enables; the pad is high-Z where the enable is 0.
- iFLASH_DIN  in  4  IO[3:0] pad inputs.
- oTIMEOUT  out  1  sticky hold-timeout flag.

## Operation
- FSM states: IDLE, OWN_SPI, OWN_QSPI, TURN.
- IDLE:
  - A single request moves to that owner.
  - Both requests: the master not served last wins. After reset, last-served is QSPI, so SPI wins the first tie.
- OWN_x: exit to TURN only when iX_REQ=0 and that owner's CS input is 1 in the same cycle. A dropped request with CS still low keeps the grant.
- TURN: lasts pTURNAROUND cycles, then goes to IDLE and rearbitrates in that IDLE cycle.
- Pin state in IDLE, TURN and reset (the idle set):
  - CSn=1, SCK=0.
  - DOUT=4'b1100, DOE=4'b1100, so HOLD/WP are driven high and IO1/IO0 are Z.
  - oSPI_MISO=0, oQSPI_DIN=0.
- OWN_SPI pins:
  - SCK=iSPI_SCK, CSn=iSPI_CSn.
  - DOUT={1,1,0,iSPI_MOSI}, DOE=4'b1101.
  - oSPI_MISO=iFLASH_DIN[1].
- OWN_QSPI pins:
  - SCK=iQSPI_SCK&!iQSPI_NCS, CSn=iQSPI_NCS.
  - DOE=iQSPI_DOE|4'b1100.
  - DOUT[i]=iQSPI_DOE[i]?iQSPI_DOUT[i]:(i>=2).
  - oQSPI_DIN=iFLASH_DIN.
- The non-owner always sees 0 on its data input.
- Hold counter:
  - Clears on entry to OWN_x.
  - Increments, saturating at pMAX_HOLD, every OWN_x cycle while the other request is high.
  - Reaching pMAX_HOLD sets oTIMEOUT. Only reset clears it.
  - No preemption: the owner keeps the bus.

## Timing
- Registered outputs: state, grants and oTIMEOUT.
- Pin muxing is combinational from the registered state, so SCK/data pass through with zero latency.
- Reset values:
  - State IDLE, both grants 0, oTIMEOUT 0.
  - Pins at the idle set from the cycle after iRESET is sampled high.
  - Reset mid-transfer aborts immediately; the bench must not expect CS to stay low.
- Grant latency: request sampled at edge n gives GNT=1 after edge n. The master must not drive CS low before it sees GNT.
- Release: the edge that samples REQ=0 and CS=1 drops GNT and enters TURN.
- Re-grant: the next grant asserts pTURNAROUND+1 edges later, one of which is the IDLE arbitration cycle. CSn stays 1 for at least pTURNAROUND+1 cycles between owners.
- Simultaneous events:
  - REQ rising in TURN waits for IDLE.
  - An owner re-requesting in the same cycle as its release still goes through TURN.

## Test plan
- Reset then iSPI_REQ=1 at cycle 3 -> oSPI_GNT=1 from cycle 4; oFLASH_DOE=4'b1101; MOSI toggles reach oFLASH_DOUT[0] in the same cycle.
- Both REQ=1 at cycle 2 -> SPI granted. SPI releases at cycle 10 with pTURNAROUND=2 -> CSn high at cycles 10-12, oQSPI_GNT=1 at cycle 13. Next tie -> SPI wins.
- SPI drops REQ while iSPI_CSn=0 for 5 cycles -> grant held; release occurs on the first cycle CSn=1.
- QSPI owner with iQSPI_DOE=4'b0000, iQSPI_NCS=0 -> oFLASH_DOUT[3:2]=2'b11, DOE=4'b1100. With DOE=4'b1111, DOUT=4'b0101 -> pins=4'b0101 and oSPI_MISO=0.
- pMAX_HOLD=8, SPI owner held 20 cycles with QSPI requesting -> oTIMEOUT=1 after the 8th waiting cycle, SPI keeps the grant, flag stays 1 until iRESET.
- iRESET pulsed during OWN_QSPI with NCS low -> next cycle grants 0, oFLASH_CSn=1, SCK=0, oTIMEOUT=0.

Source files
------------

// File: rtl/flash_pin_arbiter.sv
// Purpose: grant FSM sharing one Q-SPI flash pin set between the SPI bridge and the QSPI controller.
// Latency: grant one edge after the request is sampled; pins mux combinationally from registered state.
// Backpressure: a waiting master stalls until the owner releases (REQ low, CS high) plus the turnaround.
module flash_pin_arbiter #(
  parameter int unsigned  pTURNAROUND = 2,
  parameter logic [15:0]  pMAX_HOLD   = 16'hFFFF
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iSPI_REQ,
  output logic       oSPI_GNT,
  input  logic       iSPI_SCK,
  input  logic       iSPI_MOSI,
  input  logic       iSPI_CSn,
  output logic       oSPI_MISO,
  input  logic       iQSPI_REQ,
  output logic       oQSPI_GNT,
  input  logic       iQSPI_SCK,
  input  logic       iQSPI_NCS,
  input  logic [3:0] iQSPI_DOUT,
  input  logic [3:0] iQSPI_DOE,
  output logic [3:0] oQSPI_DIN,
  output logic       oFLASH_SCK,
  output logic       oFLASH_CSn,
  output logic [3:0] oFLASH_DOUT,
  output logic [3:0] oFLASH_DOE,
  input  logic [3:0] iFLASH_DIN,
  output logic       oTIMEOUT
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_SPI  = 2'd1,
    OWN_QSPI = 2'd2,
    TURN     = 2'd3
  } tState;

  localparam logic [3:0] TURN_LAST = 4'(pTURNAROUND - 1);
  // Idle pin set: HOLD/WP driven high, IO1/IO0 released
  localparam logic [3:0] IDLE_IO   = 4'b1100;

  tState       state;
  tState       nextState;
  logic        lastQspi;    // 1 when QSPI was the most recent owner
  logic [3:0]  turnCnt;
  logic [15:0] holdCnt;
  logic        inOwn;
  logic        otherReq;
  logic        enteringOwn;
  logic        holdHit;

  assign inOwn       = (state == OWN_SPI) || (state == OWN_QSPI);
  assign otherReq    = (state == OWN_SPI) ? iQSPI_REQ : iSPI_REQ;
  assign enteringOwn = !inOwn && ((nextState == OWN_SPI) || (nextState == OWN_QSPI));
  assign holdHit     = ({1'b0, holdCnt} + 17'd1) >= {1'b0, pMAX_HOLD};

  // State register
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: arbitrate in IDLE, release only with REQ low and CS high, fixed-length turnaround
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (iSPI_REQ && iQSPI_REQ) begin
          nextState = lastQspi ? OWN_SPI : OWN_QSPI;
        end else if (iSPI_REQ) begin
          nextState = OWN_SPI;
        end else if (iQSPI_REQ) begin
          nextState = OWN_QSPI;
        end
      end
      OWN_SPI: begin
        if (!iSPI_REQ && iSPI_CSn) nextState = TURN;
      end
      OWN_QSPI: begin
        if (!iQSPI_REQ && iQSPI_NCS) nextState = TURN;
      end
      TURN: begin
        if (turnCnt == TURN_LAST) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Registered grants, fairness memory, turnaround and hold counters, sticky timeout
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oSPI_GNT  <= 1'b0;
      oQSPI_GNT <= 1'b0;
      lastQspi  <= 1'b1;
      turnCnt   <= 4'd0;
      holdCnt   <= 16'd0;
      oTIMEOUT  <= 1'b0;
    end else begin
      oSPI_GNT  <= (nextState == OWN_SPI);
      oQSPI_GNT <= (nextState == OWN_QSPI);
      if (nextState == OWN_SPI && state == IDLE) lastQspi <= 1'b0;
      if (nextState == OWN_QSPI && state == IDLE) lastQspi <= 1'b1;
      turnCnt <= (state == TURN) ? turnCnt + 4'd1 : 4'd0;
      if (enteringOwn) begin
        holdCnt <= 16'd0;
      end else if (inOwn && otherReq && holdCnt != pMAX_HOLD) begin
        holdCnt <= holdCnt + 16'd1;
      end
      // The owner is never preempted; the flag only reports the overrun
      if (inOwn && otherReq && holdHit) oTIMEOUT <= 1'b1;
    end
  end

  // Pin mux from registered state; non-owner always sees zero data
  always_comb begin
    oFLASH_SCK  = 1'b0;
    oFLASH_CSn  = 1'b1;
    oFLASH_DOUT = IDLE_IO;
    oFLASH_DOE  = IDLE_IO;
    oSPI_MISO   = 1'b0;
    oQSPI_DIN   = 4'd0;
    case (state)
      OWN_SPI: begin
        oFLASH_SCK  = iSPI_SCK;
        oFLASH_CSn  = iSPI_CSn;
        oFLASH_DOUT = {3'b110, iSPI_MOSI};
        oFLASH_DOE  = 4'b1101;
        oSPI_MISO   = iFLASH_DIN[1];
      end
      OWN_QSPI: begin
        oFLASH_SCK  = iQSPI_SCK & ~iQSPI_NCS;
        oFLASH_CSn  = iQSPI_NCS;
        oFLASH_DOUT = (iQSPI_DOE & iQSPI_DOUT) | (~iQSPI_DOE & IDLE_IO);
        oFLASH_DOE  = iQSPI_DOE | IDLE_IO;
        oQSPI_DIN   = iFLASH_DIN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_pin_arbiter.sv
// Purpose: directed self-checking bench for flash_pin_arbiter (turnaround 2, max hold 8).
// Latency: inputs driven 1 time unit after the rising edge; outputs checked before the next edge.
// Backpressure: fixed cycle counts only, so every scenario ends on its own.
module tb_flash_pin_arbiter;

  logic       iCLK;
  logic       iRESET;
  logic       iSPI_REQ, oSPI_GNT, iSPI_SCK, iSPI_MOSI, iSPI_CSn, oSPI_MISO;
  logic       iQSPI_REQ, oQSPI_GNT, iQSPI_SCK, iQSPI_NCS;
  logic [3:0] iQSPI_DOUT, iQSPI_DOE, oQSPI_DIN;
  logic       oFLASH_SCK, oFLASH_CSn;
  logic [3:0] oFLASH_DOUT, oFLASH_DOE, iFLASH_DIN;
  logic       oTIMEOUT;

  int nChecks = 0;
  int nFails  = 0;

  flash_pin_arbiter #(.pTURNAROUND(2), .pMAX_HOLD(16'd8)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iSPI_REQ(iSPI_REQ), .oSPI_GNT(oSPI_GNT), .iSPI_SCK(iSPI_SCK),
    .iSPI_MOSI(iSPI_MOSI), .iSPI_CSn(iSPI_CSn), .oSPI_MISO(oSPI_MISO),
    .iQSPI_REQ(iQSPI_REQ), .oQSPI_GNT(oQSPI_GNT), .iQSPI_SCK(iQSPI_SCK),
    .iQSPI_NCS(iQSPI_NCS), .iQSPI_DOUT(iQSPI_DOUT), .iQSPI_DOE(iQSPI_DOE),
    .oQSPI_DIN(oQSPI_DIN), .oFLASH_SCK(oFLASH_SCK), .oFLASH_CSn(oFLASH_CSn),
    .oFLASH_DOUT(oFLASH_DOUT), .oFLASH_DOE(oFLASH_DOE), .iFLASH_DIN(iFLASH_DIN),
    .oTIMEOUT(oTIMEOUT)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset;
    iSPI_REQ = 0; iSPI_SCK = 0; iSPI_MOSI = 0; iSPI_CSn = 1;
    iQSPI_REQ = 0; iQSPI_SCK = 0; iQSPI_NCS = 1; iQSPI_DOUT = 0; iQSPI_DOE = 0;
    iRESET = 1;
    tick();
    iRESET = 0;
  endtask

  task automatic test_reset;
    iFLASH_DIN = 4'b1111;
    do_reset();
    tick();
    nChecks++; if (oSPI_GNT !== 1'b0) begin nFails++; $display("FAIL rst_spi_gnt got %b want 0", oSPI_GNT); end
    nChecks++; if (oQSPI_GNT !== 1'b0) begin nFails++; $display("FAIL rst_qspi_gnt got %b want 0", oQSPI_GNT); end
    nChecks++; if (oTIMEOUT !== 1'b0) begin nFails++; $display("FAIL rst_timeout got %b want 0", oTIMEOUT); end
    nChecks++; if ({oFLASH_CSn, oFLASH_SCK} !== 2'b10) begin nFails++; $display("FAIL rst_cs_sck got %b want 10", {oFLASH_CSn, oFLASH_SCK}); end
    nChecks++; if ({oFLASH_DOUT, oFLASH_DOE} !== 8'b1100_1100) begin nFails++; $display("FAIL rst_io got %b want 11001100", {oFLASH_DOUT, oFLASH_DOE}); end
    nChecks++; if ({oSPI_MISO, oQSPI_DIN} !== 5'b0) begin nFails++; $display("FAIL rst_din got %b want 00000", {oSPI_MISO, oQSPI_DIN}); end
  endtask

  task automatic test_spi_grant;
    iSPI_REQ = 1;
    #1;
    nChecks++; if (oSPI_GNT !== 1'b0) begin nFails++; $display("FAIL spi_gnt_early got %b want 0", oSPI_GNT); end
    tick();
    nChecks++; if ({oSPI_GNT, oQSPI_GNT} !== 2'b10) begin nFails++; $display("FAIL spi_gnt got %b want 10", {oSPI_GNT, oQSPI_GNT}); end
    nChecks++; if (oFLASH_DOE !== 4'b1101) begin nFails++; $display("FAIL spi_doe got %b want 1101", oFLASH_DOE); end
    iSPI_CSn = 0; iSPI_SCK = 1; iSPI_MOSI = 1; iFLASH_DIN = 4'b0010;
    #1;
    nChecks++; if (oFLASH_DOUT !== 4'b1101) begin nFails++; $display("FAIL spi_mosi1 got %b want 1101", oFLASH_DOUT); end
    nChecks++; if ({oFLASH_CSn, oFLASH_SCK} !== 2'b01) begin nFails++; $display("FAIL spi_cs_sck got %b want 01", {oFLASH_CSn, oFLASH_SCK}); end
    nChecks++; if ({oSPI_MISO, oQSPI_DIN} !== 5'b1_0000) begin nFails++; $display("FAIL spi_miso got %b want 10000", {oSPI_MISO, oQSPI_DIN}); end
    iSPI_MOSI = 0;
    #1;
    nChecks++; if (oFLASH_DOUT !== 4'b1100) begin nFails++; $display("FAIL spi_mosi0 got %b want 1100", oFLASH_DOUT); end
  endtask

  task automatic test_hold_cs;
    iSPI_REQ = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nChecks++; if (oSPI_GNT !== 1'b1) begin nFails++; $display("FAIL cs_low_hold[%0d] got %b want 1", i, oSPI_GNT); end
    end
    iSPI_CSn = 1; iSPI_SCK = 0;
    tick();
    nChecks++; if (oSPI_GNT !== 1'b0) begin nFails++; $display("FAIL cs_release got %b want 0", oSPI_GNT); end
    nChecks++; if ({oFLASH_CSn, oFLASH_DOE} !== 5'b1_1100) begin nFails++; $display("FAIL turn_pins got %b want 11100", {oFLASH_CSn, oFLASH_DOE}); end
    repeat (3) tick();
  endtask

  task automatic test_tie_and_turnaround;
    do_reset();
    iSPI_REQ = 1; iQSPI_REQ = 1;
    tick();
    nChecks++; if ({oSPI_GNT, oQSPI_GNT} !== 2'b10) begin nFails++; $display("FAIL tie1 got %b want 10", {oSPI_GNT, oQSPI_GNT}); end
    tick();
    iSPI_REQ = 0;
    tick();  // release edge
    iSPI_REQ = 1;  // immediate re-request must still wait out the turnaround
    for (int i = 0; i < 3; i++) begin
      nChecks++; if ({oSPI_GNT, oQSPI_GNT, oFLASH_CSn} !== 3'b001) begin nFails++; $display("FAIL turn_gap[%0d] got %b want 001", i, {oSPI_GNT, oQSPI_GNT, oFLASH_CSn}); end
      tick();
    end
    nChecks++; if ({oSPI_GNT, oQSPI_GNT} !== 2'b01) begin nFails++; $display("FAIL tie2 got %b want 01", {oSPI_GNT, oQSPI_GNT}); end
    iSPI_REQ = 0;
  endtask

  task automatic test_qspi_pins;
    iQSPI_NCS = 0; iQSPI_SCK = 1; iQSPI_DOE = 4'b0000; iQSPI_DOUT = 4'b1111; iFLASH_DIN = 4'b1010;
    #1;
    nChecks++; if ({oFLASH_DOUT, oFLASH_DOE} !== 8'b1100_1100) begin nFails++; $display("FAIL q_doe0 got %b want 11001100", {oFLASH_DOUT, oFLASH_DOE}); end
    nChecks++; if ({oFLASH_CSn, oFLASH_SCK} !== 2'b01) begin nFails++; $display("FAIL q_cs_sck got %b want 01", {oFLASH_CSn, oFLASH_SCK}); end
    nChecks++; if ({oSPI_MISO, oQSPI_DIN} !== 5'b0_1010) begin nFails++; $display("FAIL q_din got %b want 01010", {oSPI_MISO, oQSPI_DIN}); end
    iQSPI_DOE = 4'b1111; iQSPI_DOUT = 4'b0101;
    #1;
    nChecks++; if ({oFLASH_DOUT, oFLASH_DOE} !== 8'b0101_1111) begin nFails++; $display("FAIL q_doe1 got %b want 01011111", {oFLASH_DOUT, oFLASH_DOE}); end
    iQSPI_DOE = 4'b0011; iQSPI_DOUT = 4'b0000;
    #1;
    nChecks++; if ({oFLASH_DOUT, oFLASH_DOE} !== 8'b1100_1111) begin nFails++; $display("FAIL q_doe_mix got %b want 11001111", {oFLASH_DOUT, oFLASH_DOE}); end
    iQSPI_NCS = 1;
    #1;
    nChecks++; if ({oFLASH_CSn, oFLASH_SCK} !== 2'b10) begin nFails++; $display("FAIL q_sck_gate got %b want 10", {oFLASH_CSn, oFLASH_SCK}); end
    iQSPI_REQ = 0; iQSPI_SCK = 0;
    tick();  // release edge
    nChecks++; if (oQSPI_GNT !== 1'b0) begin nFails++; $display("FAIL q_release got %b want 0", oQSPI_GNT); end
    iSPI_REQ = 1; iQSPI_REQ = 1;  // requests rising during the turnaround
    tick(); tick();
    nChecks++; if ({oSPI_GNT, oQSPI_GNT} !== 2'b00) begin nFails++; $display("FAIL turn_wait got %b want 00", {oSPI_GNT, oQSPI_GNT}); end
    tick();
    nChecks++; if ({oSPI_GNT, oQSPI_GNT} !== 2'b10) begin nFails++; $display("FAIL tie3 got %b want 10", {oSPI_GNT, oQSPI_GNT}); end
  endtask

  task automatic test_timeout;
    do_reset();
    iSPI_REQ = 1;
    tick();
    iSPI_CSn = 0; iQSPI_REQ = 1;
    repeat (7) tick();
    nChecks++; if (oTIMEOUT !== 1'b0) begin nFails++; $display("FAIL to_early got %b want 0", oTIMEOUT); end
    tick();
    nChecks++; if (oTIMEOUT !== 1'b1) begin nFails++; $display("FAIL to_set got %b want 1", oTIMEOUT); end
    repeat (12) tick();
    nChecks++; if ({oSPI_GNT, oQSPI_GNT, oTIMEOUT} !== 3'b101) begin nFails++; $display("FAIL to_keep got %b want 101", {oSPI_GNT, oQSPI_GNT, oTIMEOUT}); end
    iQSPI_REQ = 0; iSPI_REQ = 0; iSPI_CSn = 1;
    repeat (4) tick();
    nChecks++; if ({oSPI_GNT, oTIMEOUT} !== 2'b01) begin nFails++; $display("FAIL to_sticky got %b want 01", {oSPI_GNT, oTIMEOUT}); end
  endtask

  task automatic test_reset_mid;
    iQSPI_REQ = 1;
    tick();
    iQSPI_NCS = 0; iQSPI_SCK = 1;
    #1;
    nChecks++; if ({oQSPI_GNT, oFLASH_CSn, oFLASH_SCK} !== 3'b101) begin nFails++; $display("FAIL mid_own got %b want 101", {oQSPI_GNT, oFLASH_CSn, oFLASH_SCK}); end
    iRESET = 1;
    tick();
    iRESET = 0;
    nChecks++; if ({oSPI_GNT, oQSPI_GNT, oTIMEOUT} !== 3'b000) begin nFails++; $display("FAIL mid_rst_regs got %b want 000", {oSPI_GNT, oQSPI_GNT, oTIMEOUT}); end
    nChecks++; if ({oFLASH_CSn, oFLASH_SCK, oFLASH_DOE} !== 6'b10_1100) begin nFails++; $display("FAIL mid_rst_pins got %b want 101100", {oFLASH_CSn, oFLASH_SCK, oFLASH_DOE}); end
  endtask

  initial begin
    iRESET = 1; iFLASH_DIN = 0;
    iSPI_REQ = 0; iSPI_SCK = 0; iSPI_MOSI = 0; iSPI_CSn = 1;
    iQSPI_REQ = 0; iQSPI_SCK = 0; iQSPI_NCS = 1; iQSPI_DOUT = 0; iQSPI_DOE = 0;
    test_reset();
    test_spi_grant();
    test_hold_cs();
    test_tie_and_turnaround();
    test_qspi_pins();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
